alu_cmd_sequencer: RTL and testbench
====================================

ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have parameter: DEPTH, 4, command FIFO entries (power of 2, >=2).
REQ-002 SHALL have port: clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port: rstn  input  1  asynchronous, active-low reset.
REQ-004 SHALL have ports: cmd_valid input 1, cmd_ready output 1; command handshake.
REQ-005 SHALL have ports: cmd_op input 3 (0 add, 1 mul, 2 sub, 3 mul-add), cmd_width input 3 (0=8b, 1=16b, 2=32b, 3=64b).
REQ-006 SHALL have ports: cmd_a, cmd_b, cmd_c  input  64 each  operands.
REQ-007 SHALL have ports: alu_a, alu_b, alu_c output 64; alu_operation output 3; alu_num_bits output 3; alu_enable output 1; drive the downstream combinational ALU.
REQ-008 SHALL have port: alu_out  input  64  ALU result.
REQ-009 SHALL have ports: rsp_valid output 1, rsp_ready input 1, rsp_data output 64, rsp_err output 1.

Function
REQ-010 SHALL accept a command on a rising edge with cmd_valid&&cmd_ready; cmd_ready = FIFO not full (registered count, no same-cycle pop bypass).
REQ-011 SHALL store commands in a DEPTH-entry FIFO with wrapping read/write pointers; order preserved.
REQ-012 SHALL run FSM IDLE -> DRIVE -> HOLD -> IDLE.
REQ-013 IDLE: if FIFO non-empty, SHALL pop head into issue registers on the edge and enter DRIVE; else stay.
REQ-014 DRIVE: SHALL assert alu_enable for exactly this one cycle, capture alu_out into rsp_data at the closing edge, set rsp_valid, enter HOLD.
REQ-015 HOLD: SHALL hold rsp_valid/rsp_data/rsp_err stable until rsp_ready sampled high, then clear rsp_valid and enter IDLE.
REQ-016 Latency: command accepted at edge T SHALL give rsp_valid high after edge T+2 (FIFO empty, FSM in IDLE); min 3 cycles per command.
REQ-017 Before driving, SHALL zero alu_a/alu_b/alu_c bits above operating width (8/16/32/64); mul-add result thus truncates to operating width.
REQ-018 alu_a/b/c, alu_operation, alu_num_bits SHALL be driven from issue registers (stable whole DRIVE cycle); alu_enable=0 outside DRIVE.
REQ-019 cmd_op>3 or cmd_width>3: SHALL skip ALU (alu_enable stays 0 in DRIVE), rsp_data=0, rsp_err=1; legal commands rsp_err=0.
REQ-020 Arithmetic wraps modulo 2^width; no overflow flag.
REQ-021 Push while FIFO full SHALL not occur (cmd_ready=0); push in same cycle as pop SHALL update count by 0.

Reset
REQ-022 rstn low SHALL immediately clear FIFO (pointers, count), FSM to IDLE, rsp_valid=0, rsp_data=0, rsp_err=0, alu_enable=0, alu_* data/control=0; cmd_ready=1 while rstn high and empty.
REQ-023 Reset mid-operation SHALL discard queued and in-flight commands; no response produced for them.

Configuration
REQ-024 With ALU_SEQ_TAG_EN defined, SHALL add cmd_tag input 4 and rsp_tag output 4; tag stored per FIFO entry, presented with its response, reset 0.
REQ-025 Without ALU_SEQ_TAG_EN, cmd_tag/rsp_tag SHALL not exist; FIFO width excludes tag; behaviour otherwise identical.

Verification
REQ-026 op=0,width=0,a=0x1FF,b=0x02 -> alu_a=0xFF, rsp_data=0x01, rsp_err=0, rsp_valid after edge T+2.
REQ-027 op=3,width=1,a=0x0100,b=0x0100,c=0x5 -> rsp_data=0x0005 (product wraps 16b).
REQ-028 op=2,width=3,a=0,b=1 -> rsp_data=0xFFFF_FFFF_FFFF_FFFF; op=5 -> rsp_data=0, rsp_err=1, alu_enable never high.
REQ-029 rsp_ready=0, push 5 commands (DEPTH=4) -> 1 in HOLD + 4 queued, cmd_ready=0; release rsp_ready -> 5 responses in order.
REQ-030 rstn low during DRIVE with 3 queued -> all outputs 0 immediately, no responses after rstn high.
REQ-031 ALU_SEQ_TAG_EN defined, tags 0xA,0x3 -> rsp_tag 0xA then 0x3 matching responses.

Source files
------------

// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: queues ALU commands in a DEPTH-entry FIFO and issues
// them one at a time to a downstream combinational ALU, returning each result
// over a valid/ready response channel.
// Optional feature: define ALU_SEQ_TAG_EN to add cmd_tag/rsp_tag (4-bit tag
// carried through the FIFO alongside each command).
module alu_cmd_sequencer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [2:0]  cmd_op,
  input  logic [2:0]  cmd_width,
  input  logic [63:0] cmd_a,
  input  logic [63:0] cmd_b,
  input  logic [63:0] cmd_c,
`ifdef ALU_SEQ_TAG_EN
  input  logic [3:0]  cmd_tag,
  output logic [3:0]  rsp_tag,
`endif
  output logic [63:0] alu_a,
  output logic [63:0] alu_b,
  output logic [63:0] alu_c,
  output logic [2:0]  alu_operation,
  output logic [2:0]  alu_num_bits,
  output logic        alu_enable,
  input  logic [63:0] alu_out,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [63:0] rsp_data,
  output logic        rsp_err
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);

  typedef enum logic [1:0] {IDLE, DRIVE, HOLD} state_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [2:0]  width;
    logic [63:0] a;
    logic [63:0] b;
    logic [63:0] c;
`ifdef ALU_SEQ_TAG_EN
    logic [3:0]  tag;
`endif
  } entry_t;

  entry_t          mem [DEPTH];
  entry_t          push_entry;
  entry_t          head;
  logic [PW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic            push, pop;
  state_t          state_q, state_d;

  logic [63:0]     issue_a, issue_b, issue_c;
  logic [2:0]      issue_op, issue_width;
  logic            issue_err;
  logic [63:0]     head_mask;
  logic            head_err;
`ifdef ALU_SEQ_TAG_EN
  logic [3:0]      issue_tag;
`endif

  function automatic logic [63:0] width_mask(input logic [2:0] w);
    case (w)
      3'd0:    width_mask = 64'h0000_0000_0000_00FF;
      3'd1:    width_mask = 64'h0000_0000_0000_FFFF;
      3'd2:    width_mask = 64'h0000_0000_FFFF_FFFF;
      3'd3:    width_mask = '1;
      default: width_mask = '0;
    endcase
  endfunction

  assign cmd_ready = (count != CW'(DEPTH));
  assign push      = cmd_valid && cmd_ready;
  assign head      = mem[rd_ptr];
  assign head_err  = (head.op > 3'd3) || (head.width > 3'd3);
  // Illegal commands issue all-zero operands since the ALU is never enabled.
  assign head_mask = head_err ? '0 : width_mask(head.width);

  always_comb begin
    push_entry       = '0;
    push_entry.op    = cmd_op;
    push_entry.width = cmd_width;
    push_entry.a     = cmd_a;
    push_entry.b     = cmd_b;
    push_entry.c     = cmd_c;
`ifdef ALU_SEQ_TAG_EN
    push_entry.tag   = cmd_tag;
`endif
  end

  // FIFO storage; contents need no reset since pointers/count gate their use.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_entry;
  end

  // FIFO pointers and occupancy; simultaneous push and pop leave count unchanged.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM next state, FIFO pop and ALU enable.
  always_comb begin
    state_d    = state_q;
    pop        = 1'b0;
    alu_enable = 1'b0;
    case (state_q)
      IDLE: begin
        if (count != '0) begin
          pop     = 1'b1;
          state_d = DRIVE;
        end
      end
      DRIVE: begin
        alu_enable = ~issue_err;
        state_d    = HOLD;
      end
      HOLD: begin
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Issue registers: loaded on pop with operands masked to the operating width.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      issue_a     <= '0;
      issue_b     <= '0;
      issue_c     <= '0;
      issue_op    <= '0;
      issue_width <= '0;
      issue_err   <= 1'b0;
`ifdef ALU_SEQ_TAG_EN
      issue_tag   <= '0;
`endif
    end else if (pop) begin
      issue_a     <= head.a & head_mask;
      issue_b     <= head.b & head_mask;
      issue_c     <= head.c & head_mask;
      issue_op    <= head.op;
      issue_width <= head.width;
      issue_err   <= head_err;
`ifdef ALU_SEQ_TAG_EN
      issue_tag   <= head.tag;
`endif
    end
  end

  // Response registers: capture at the end of DRIVE, hold until accepted.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rsp_valid <= 1'b0;
      rsp_data  <= '0;
      rsp_err   <= 1'b0;
`ifdef ALU_SEQ_TAG_EN
      rsp_tag   <= '0;
`endif
    end else if (state_q == DRIVE) begin
      rsp_valid <= 1'b1;
      rsp_data  <= issue_err ? '0 : alu_out;
      rsp_err   <= issue_err;
`ifdef ALU_SEQ_TAG_EN
      rsp_tag   <= issue_tag;
`endif
    end else if (state_q == HOLD && rsp_ready) begin
      rsp_valid <= 1'b0;
    end
  end

  assign alu_a         = issue_a;
  assign alu_b         = issue_b;
  assign alu_c         = issue_c;
  assign alu_operation = issue_op;
  assign alu_num_bits  = issue_width;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Testbench for alu_cmd_sequencer: acts as the downstream ALU, drives
// directed and random commands, and checks every response against a queue
// of results computed from the operation rules.
module tb_alu_cmd_sequencer;

  logic        clk;
  logic        rstn;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [2:0]  cmd_op;
  logic [2:0]  cmd_width;
  logic [63:0] cmd_a, cmd_b, cmd_c;
  logic [63:0] alu_a, alu_b, alu_c;
  logic [2:0]  alu_operation;
  logic [2:0]  alu_num_bits;
  logic        alu_enable;
  logic [63:0] alu_out;
  logic [63:0] alu_raw;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_data;
  logic        rsp_err;
  logic [3:0]  cmd_tag;
`ifdef ALU_SEQ_TAG_EN
  logic [3:0]  rsp_tag;
`endif

  typedef struct {
    logic [63:0] data;
    logic        err;
    logic [3:0]  tag;
  } exp_t;

  exp_t q[$];
  int unsigned n_checks = 0;
  int unsigned n_errors = 0;
  int unsigned en_cycles = 0;
  int unsigned legal_rsp = 0;
  int unsigned rsp_count = 0;

  alu_cmd_sequencer #(.DEPTH(4)) dut (
    .clk           (clk),
    .rstn          (rstn),
    .cmd_valid     (cmd_valid),
    .cmd_ready     (cmd_ready),
    .cmd_op        (cmd_op),
    .cmd_width     (cmd_width),
    .cmd_a         (cmd_a),
    .cmd_b         (cmd_b),
    .cmd_c         (cmd_c),
`ifdef ALU_SEQ_TAG_EN
    .cmd_tag       (cmd_tag),
    .rsp_tag       (rsp_tag),
`endif
    .alu_a         (alu_a),
    .alu_b         (alu_b),
    .alu_c         (alu_c),
    .alu_operation (alu_operation),
    .alu_num_bits  (alu_num_bits),
    .alu_enable    (alu_enable),
    .alu_out       (alu_out),
    .rsp_valid     (rsp_valid),
    .rsp_ready     (rsp_ready),
    .rsp_data      (rsp_data),
    .rsp_err       (rsp_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] wmask(input int unsigned w);
    case (w)
      0:       return 64'hFF;
      1:       return 64'hFFFF;
      2:       return 64'hFFFF_FFFF;
      3:       return {64{1'b1}};
      default: return 64'h0;
    endcase
  endfunction

  // Downstream ALU: result wraps to the operating width.
  always_comb begin
    alu_raw = '0;
    case (alu_operation)
      3'd0:    alu_raw = alu_a + alu_b;
      3'd1:    alu_raw = alu_a * alu_b;
      3'd2:    alu_raw = alu_a - alu_b;
      3'd3:    alu_raw = alu_a * alu_b + alu_c;
      default: alu_raw = '0;
    endcase
    alu_out = alu_raw & wmask(int'(alu_num_bits));
  end

  // Expected response from the command rules.
  function automatic exp_t model(input int unsigned op, input int unsigned w,
                                 input logic [63:0] a, input logic [63:0] b,
                                 input logic [63:0] c, input logic [3:0] tag);
    exp_t e;
    logic [63:0] m;
    e.tag = tag;
    if (op > 3 || w > 3) begin
      e.data = 64'h0;
      e.err  = 1'b1;
    end else begin
      m = wmask(w);
      a = a & m; b = b & m; c = c & m;
      case (op)
        0:       e.data = a + b;
        1:       e.data = a * b;
        2:       e.data = a - b;
        default: e.data = a * b + c;
      endcase
      e.data = e.data & m;
      e.err  = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic set_cmd(input int unsigned op, input int unsigned w, input logic [63:0] a,
                         input logic [63:0] b, input logic [63:0] c, input logic [3:0] tag);
    cmd_op    = op[2:0];
    cmd_width = w[2:0];
    cmd_a     = a;
    cmd_b     = b;
    cmd_c     = c;
    cmd_tag   = tag;
  endtask

  // One clock: record handshakes seen before the edge, then advance to #1 after it.
  task automatic tick();
    bit          was_hold;
    logic [63:0] h_data;
    logic        h_err;
    exp_t        e;
    was_hold = rsp_valid && !rsp_ready;
    h_data   = rsp_data;
    h_err    = rsp_err;
    if (alu_enable) begin
      en_cycles++;
      check("en_legal", 64'((alu_operation > 3'd3) || (alu_num_bits > 3'd3)), 64'h0);
      check("alu_a_hi", alu_a & ~wmask(int'(alu_num_bits)), 64'h0);
      check("alu_b_hi", alu_b & ~wmask(int'(alu_num_bits)), 64'h0);
      check("alu_c_hi", alu_c & ~wmask(int'(alu_num_bits)), 64'h0);
    end
    if (cmd_valid && cmd_ready)
      q.push_back(model(int'(cmd_op), int'(cmd_width), cmd_a, cmd_b, cmd_c, cmd_tag));
    if (rsp_valid && rsp_ready) begin
      rsp_count++;
      if (q.size() == 0) begin
        check("unexpected_rsp", 64'h1, 64'h0);
      end else begin
        e = q.pop_front();
        if (!e.err) legal_rsp++;
        check("rsp_data", rsp_data, e.data);
        check("rsp_err", 64'(rsp_err), 64'(e.err));
`ifdef ALU_SEQ_TAG_EN
        check("rsp_tag", 64'(rsp_tag), 64'(e.tag));
`endif
      end
    end
    @(posedge clk);
    #1;
    if (was_hold) begin
      check("hold_valid", 64'(rsp_valid), 64'h1);
      check("hold_data", rsp_data, h_data);
      check("hold_err", 64'(rsp_err), 64'(h_err));
    end
  endtask

  // Push one command into an idle, empty sequencer and check its response.
  task automatic run_one(input string name, input int unsigned op, input int unsigned w,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                         input logic [63:0] exp_data, input logic exp_err);
    set_cmd(op, w, a, b, c, 4'h0);
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    check({name, "_valid"}, 64'(rsp_valid), 64'h1);
    check({name, "_data"}, rsp_data, exp_data);
    check({name, "_err"}, 64'(rsp_err), 64'(exp_err));
    tick();
  endtask

  // Fill with rsp_ready low: one response held, DEPTH commands queued.
  task automatic fill_five(input int unsigned base);
    int unsigned sent;
    sent = 0;
    rsp_ready = 1'b0;
    for (int i = 0; i < 20 && sent < 5; i++) begin
      set_cmd(0, 1, 64'(base + sent), 64'h10, 64'h0, 4'(sent));
      cmd_valid = 1'b1;
      if (cmd_ready) sent++;
      tick();
    end
    cmd_valid = 1'b0;
    check("fill_sent", 64'(sent), 64'd5);
    check("full_cmd_ready", 64'(cmd_ready), 64'h0);
    check("full_rsp_valid", 64'(rsp_valid), 64'h1);
  endtask

  initial begin
    int unsigned snap_en, snap_rsp;
    rstn      = 1'b0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    set_cmd(0, 0, 64'h0, 64'h0, 64'h0, 4'h0);
    repeat (3) @(posedge clk);
    #1;
    check("rst_rsp_valid", 64'(rsp_valid), 64'h0);
    check("rst_rsp_data", rsp_data, 64'h0);
    check("rst_alu_enable", 64'(alu_enable), 64'h0);
    check("rst_alu_a", alu_a, 64'h0);
    rstn = 1'b1;
    #1;
    check("rst_cmd_ready", 64'(cmd_ready), 64'h1);
`ifdef ALU_SEQ_TAG_EN
    check("rst_rsp_tag", 64'(rsp_tag), 64'h0);
`endif
    tick();

    // Latency: accept at edge T, valid after edge T+2.
    set_cmd(0, 0, 64'h1FF, 64'h02, 64'h0, 4'h0);
    cmd_valid = 1'b1;
    rsp_ready = 1'b1;
    tick();
    cmd_valid = 1'b0;
    check("lat_t1_valid", 64'(rsp_valid), 64'h0);
    check("lat_t1_en", 64'(alu_enable), 64'h0);
    tick();
    check("drive_en", 64'(alu_enable), 64'h1);
    check("drive_alu_a", alu_a, 64'hFF);
    check("drive_alu_b", alu_b, 64'h02);
    tick();
    check("lat_t2_valid", 64'(rsp_valid), 64'h1);
    check("lat_data", rsp_data, 64'h01);
    check("lat_err", 64'(rsp_err), 64'h0);
    check("after_drive_en", 64'(alu_enable), 64'h0);
    tick();
    check("rsp_cleared", 64'(rsp_valid), 64'h0);

    run_one("muladd16", 3, 1, 64'h0100, 64'h0100, 64'h5, 64'h0005, 1'b0);
    run_one("sub64", 2, 3, 64'h0, 64'h1, 64'h0, {64{1'b1}}, 1'b0);
    snap_en = en_cycles;
    run_one("bad_op", 5, 0, 64'h12, 64'h34, 64'h0, 64'h0, 1'b1);
    run_one("bad_width", 0, 6, 64'h12, 64'h34, 64'h0, 64'h0, 1'b1);
    check("illegal_no_en", 64'(en_cycles - snap_en), 64'h0);

    // Back-pressure: 1 held + 4 queued, then 5 in-order responses.
    snap_rsp = rsp_count;
    fill_five(100);
    rsp_ready = 1'b1;
    for (int i = 0; i < 40 && q.size() != 0; i++) tick();
    check("bp_drained", 64'(q.size()), 64'h0);
    check("bp_rsp_count", 64'(rsp_count - snap_rsp), 64'd5);

    // Random traffic with legal and illegal commands.
    for (int i = 0; i < 500; i++) begin
      int unsigned op, w;
      op = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7);
      w  = ($urandom_range(0, 9) < 8) ? $urandom_range(0, 3) : $urandom_range(4, 7);
      set_cmd(op, w, {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom},
              4'($urandom));
      cmd_valid = ($urandom_range(0, 2) != 0);
      rsp_ready = ($urandom_range(0, 9) < 6);
      tick();
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int i = 0; i < 60 && (q.size() != 0 || rsp_valid); i++) tick();
    check("rand_drained", 64'(q.size()), 64'h0);
    check("en_vs_legal", 64'(en_cycles), 64'(legal_rsp));

    // Reset during DRIVE with 3 commands still queued.
    fill_five(200);
    rsp_ready = 1'b1;
    tick();
    tick();
    check("pre_rst_drive", 64'(alu_enable), 64'h1);
    #2;
    rstn = 1'b0;
    #1;
    q.delete();
    check("mid_rst_valid", 64'(rsp_valid), 64'h0);
    check("mid_rst_data", rsp_data, 64'h0);
    check("mid_rst_err", 64'(rsp_err), 64'h0);
    check("mid_rst_en", 64'(alu_enable), 64'h0);
    check("mid_rst_alu_a", alu_a, 64'h0);
    check("mid_rst_alu_op", 64'(alu_operation), 64'h0);
    check("mid_rst_alu_bits", 64'(alu_num_bits), 64'h0);
    check("mid_rst_ready", 64'(cmd_ready), 64'h1);
    repeat (2) @(posedge clk);
    #1;
    rstn = 1'b1;
    snap_rsp = rsp_count;
    snap_en  = en_cycles;
    for (int i = 0; i < 20; i++) tick();
    check("post_rst_no_rsp", 64'(rsp_count - snap_rsp), 64'h0);
    check("post_rst_no_en", 64'(en_cycles - snap_en), 64'h0);

`ifdef ALU_SEQ_TAG_EN
    // Tags travel with their commands.
    rsp_ready = 1'b0;
    set_cmd(0, 0, 64'h1, 64'h1, 64'h0, 4'hA);
    cmd_valid = 1'b1;
    tick();
    set_cmd(0, 0, 64'h2, 64'h2, 64'h0, 4'h3);
    tick();
    cmd_valid = 1'b0;
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    check("tag_first", 64'(rsp_tag), 64'hA);
    check("tag_first_data", rsp_data, 64'h2);
    rsp_ready = 1'b1;
    tick();
    for (int i = 0; i < 10 && !rsp_valid; i++) tick();
    check("tag_second", 64'(rsp_tag), 64'h3);
    check("tag_second_data", rsp_data, 64'h4);
    tick();
    check("tag_drained", 64'(q.size()), 64'h0);
`endif

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
